input_poll_sequencer: RTL and testbench

Sequences DB9 controller polling for both ports and decides when a poll runs: on vblank, a CPU strobe, or a free-running divider. It drives the select lines with a programmable settle time, samples both multiplexed phases and debounces across polls. It publishes a CPU-coherent snapshot through a request/acknowledge handshake. It sits between the DB9 pins and the CPU register decoder, which reads `buttons*`, `pressed*` and `busy`.

---
 rtl/input_pkg.sv | 35 +++
 rtl/input_debounce.sv | 38 +++
 rtl/input_poll_sequencer.sv | 142 ++++++++++++++
 tb/tb_input_poll_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// input_pkg: shared state codes, button bit positions and DB9 phase decoders
package input_pkg;

    localparam int BTN_W = 12;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEL_LO  = 3'd1;
    localparam logic [2:0] SAMP_LO = 3'd2;
    localparam logic [2:0] SEL_HI  = 3'd3;
    localparam logic [2:0] SAMP_HI = 3'd4;
    localparam logic [2:0] PUBLISH = 3'd5;

    localparam int UP     = 0;
    localparam int DOWN   = 1;
    localparam int LEFT   = 2;
    localparam int RIGHT  = 3;
    localparam int BTN_A  = 4;
    localparam int BTN_B  = 5;
    localparam int BTN_C  = 6;
    localparam int BTN_L  = 7;
    localparam int BTN_R  = 8;
    localparam int SELECT = 9;
    localparam int START  = 10;

    // select-low phase: B, A, pins 3..0 (already inverted to active high)
    function automatic logic [5:0] lo_bits(input logic [8:0] p);
        return {p[8], p[5], p[3], p[2], p[1], p[0]};
    endfunction

    // select-high phase: START, SELECT, R, L, C
    function automatic logic [4:0] hi_bits(input logic [8:0] p);
        return {p[2], p[3], p[1], p[0], p[5]};
    endfunction

endpackage

// File: rtl/input_debounce.sv
// input_debounce: per-port poll-to-poll debounce; live includes an in-flight publish
module input_debounce
    import input_pkg::*;
#(
    parameter int DEBOUNCE_POLLS = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             publish,
    input  logic [BTN_W-1:0] raw,
    output logic [BTN_W-1:0] live,
    output logic [BTN_W-1:0] rise
);

    logic [BTN_W-1:0] prev, held;
    logic [3:0]       cnt, cnt_next;

    // stable-poll count after this poll and the state accepted if publishing now
    always_comb begin
        cnt_next = (raw != prev) ? 4'd1 : (cnt == 4'(DEBOUNCE_POLLS)) ? cnt : cnt + 4'd1;
        live     = (publish && cnt_next == 4'(DEBOUNCE_POLLS)) ? raw : held;
        rise     = live & ~held;
    end

    // commit history and accepted state once per poll
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
            cnt  <= '0;
            held <= '0;
        end else if (publish) begin
            prev <= raw;
            cnt  <= cnt_next;
            held <= live;
        end
    end

endmodule

// File: rtl/input_poll_sequencer.sv
// input_poll_sequencer: DB9 poll sequencing, debounce and CPU snapshot (INPUT_EDGE_DETECT_EN adds sticky pressed flags)
module input_poll_sequencer
    import input_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_POLLS = 3,
    parameter int POLL_DIV       = 10000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vblank_pulse,
    input  logic             poll_req,
    input  logic [8:0]       db9_1,
    input  logic [8:0]       db9_2,
    output logic             db9_1_select,
    output logic             db9_2_select,
    input  logic             snap_req,
    output logic             snap_ack,
    output logic [BTN_W-1:0] buttons1,
    output logic [BTN_W-1:0] buttons2,
    output logic [BTN_W-1:0] pressed1,
    output logic [BTN_W-1:0] pressed2,
    input  logic             pressed_clr,
    output logic             busy,
    output logic [7:0]       poll_count
);

    logic [2:0]       state, state_next;
    logic [7:0]       settle_cnt;
    logic [31:0]      div_cnt;
    logic [8:0]       s1a, s1b, s2a, s2b, p1, p2;
    logic [BTN_W-1:0] raw1, raw2, live1, live2, rise1, rise2;
    logic             pending, div_tc, trigger, settle_done, publish;

    assign p1           = ~s1b;
    assign p2           = ~s2b;
    assign div_tc       = (POLL_DIV != 0) && (div_cnt == 32'(POLL_DIV - 1));
    assign trigger      = vblank_pulse | poll_req | div_tc;
    assign settle_done  = settle_cnt == 8'(SETTLE_CYCLES - 1);
    assign publish      = state == PUBLISH;
    assign busy         = state != IDLE;
    assign db9_1_select = !(state == SEL_LO || state == SAMP_LO);
    assign db9_2_select = db9_1_select;

    // two-flop synchronizers; idle pins read high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {s1a, s1b, s2a, s2b} <= '1;
        end else begin
            s1a <= db9_1;
            s1b <= s1a;
            s2a <= db9_2;
            s2b <= s2a;
        end
    end

    // poll sequence: settle low, sample, settle high, sample, publish
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger || pending) state_next = SEL_LO;
            SEL_LO:  if (settle_done) state_next = SAMP_LO;
            SAMP_LO: state_next = SEL_HI;
            SEL_HI:  if (settle_done) state_next = SAMP_HI;
            SAMP_HI: state_next = PUBLISH;
            default: state_next = IDLE;
        endcase
    end

    // sequencer state, settle timer, free-running divider and one-deep pending trigger
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            div_cnt    <= '0;
            pending    <= 1'b0;
            poll_count <= '0;
        end else begin
            state      <= state_next;
            settle_cnt <= ((state == SEL_LO || state == SEL_HI) && !settle_done) ? settle_cnt + 8'd1 : 8'd0;
            div_cnt    <= div_tc ? 32'd0 : div_cnt + 32'd1;
            pending    <= (state == IDLE) ? 1'b0 : (pending | trigger);
            poll_count <= poll_count + 8'(publish);
        end
    end

    // capture both multiplexed phases into the raw vectors; bit 11 stays 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            raw1 <= '0;
            raw2 <= '0;
        end else if (state == SAMP_LO) begin
            raw1[BTN_B:UP] <= lo_bits(p1);
            raw2[BTN_B:UP] <= lo_bits(p2);
        end else if (state == SAMP_HI) begin
            raw1[START:BTN_C] <= hi_bits(p1);
            raw2[START:BTN_C] <= hi_bits(p2);
        end
    end

    input_debounce #(.DEBOUNCE_POLLS(DEBOUNCE_POLLS)) u_deb1 (
        .clk(clk), .reset_n(reset_n), .publish(publish), .raw(raw1), .live(live1), .rise(rise1)
    );

    input_debounce #(.DEBOUNCE_POLLS(DEBOUNCE_POLLS)) u_deb2 (
        .clk(clk), .reset_n(reset_n), .publish(publish), .raw(raw2), .live(live2), .rise(rise2)
    );

    // snapshot copies live state (including a same-cycle publish) and acks next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_ack <= 1'b0;
            buttons1 <= '0;
            buttons2 <= '0;
        end else begin
            snap_ack <= snap_req;
            if (snap_req) begin
                buttons1 <= live1;
                buttons2 <= live2;
            end
        end
    end

`ifdef INPUT_EDGE_DETECT_EN
    // sticky rise flags; a new rise outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pressed1 <= '0;
            pressed2 <= '0;
        end else begin
            pressed1 <= (pressed_clr ? '0 : pressed1) | rise1;
            pressed2 <= (pressed_clr ? '0 : pressed2) | rise2;
        end
    end
`else
    logic unused_edge;
    assign unused_edge = ^{rise1, rise2, pressed_clr};
    assign pressed1    = '0;
    assign pressed2    = '0;
`endif

endmodule

// File: tb/tb_input_poll_sequencer.sv
// tb_input_poll_sequencer: directed tests for polling, debounce, pending and snapshot
module tb_input_poll_sequencer;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        vblank_pulse = 1'b0, poll_req = 1'b0, snap_req = 1'b0, pressed_clr = 1'b0;
    logic [8:0]  lo1 = 9'h1FF, hi1 = 9'h1FF, lo2 = 9'h1FF, hi2 = 9'h1FF;
    logic [8:0]  db9_1, db9_2;
    logic        db9_1_select, db9_2_select, snap_ack, busy;
    logic [11:0] buttons1, buttons2, pressed1, pressed2;
    logic [7:0]  poll_count;
    int          checks = 0, errors = 0, polls_done = 0;

    assign db9_1 = db9_1_select ? hi1 : lo1;
    assign db9_2 = db9_2_select ? hi2 : lo2;

    always #5 clk = ~clk;

    input_poll_sequencer dut (
        .clk(clk), .reset_n(reset_n), .vblank_pulse(vblank_pulse), .poll_req(poll_req),
        .db9_1(db9_1), .db9_2(db9_2), .db9_1_select(db9_1_select), .db9_2_select(db9_2_select),
        .snap_req(snap_req), .snap_ack(snap_ack), .buttons1(buttons1), .buttons2(buttons2),
        .pressed1(pressed1), .pressed2(pressed2), .pressed_clr(pressed_clr), .busy(busy),
        .poll_count(poll_count)
    );

    task automatic poll();
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (35) @(negedge clk);
        polls_done++;
    endtask

    task automatic snap();
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
    endtask

    task automatic clear_pressed();
        @(negedge clk);
        pressed_clr = 1'b1;
        @(negedge clk);
        pressed_clr = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic sel_lo, sel2_lo, sel_hi;
        repeat (3) @(negedge clk);
        checks++; if (buttons1 !== 12'h000 || buttons2 !== 12'h000) begin errors++; $display("FAIL reset_buttons: got %h/%h expected 000/000", buttons1, buttons2); end
        checks++; if (db9_1_select !== 1'b1 || db9_2_select !== 1'b1) begin errors++; $display("FAIL reset_select: got %b/%b expected 1/1", db9_1_select, db9_2_select); end
        checks++; if (busy !== 1'b0 || snap_ack !== 1'b0 || poll_count !== 8'd0) begin errors++; $display("FAIL reset_ctrl: busy %b ack %b count %0d expected 0 0 0", busy, snap_ack, poll_count); end
        checks++; if (pressed1 !== 12'h000 || pressed2 !== 12'h000) begin errors++; $display("FAIL reset_pressed: got %h/%h expected 000/000", pressed1, pressed2); end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        n = 0;
        sel_lo = db9_1_select;
        sel2_lo = db9_2_select;
        sel_hi = 1'b0;
        for (int i = 0; i < 60 && busy; i++) begin
            n++;
            if (i == 19) sel_hi = db9_1_select;
            @(negedge clk);
        end
        polls_done++;
        checks++; if (n != 35) begin errors++; $display("FAIL busy_len: got %0d expected 35", n); end
        checks++; if (sel_lo !== 1'b0 || sel2_lo !== 1'b0) begin errors++; $display("FAIL sel_lo_phase: got %b/%b expected 0/0", sel_lo, sel2_lo); end
        checks++; if (sel_hi !== 1'b1) begin errors++; $display("FAIL sel_hi_phase: got %b expected 1", sel_hi); end
        checks++; if (poll_count !== 8'd1) begin errors++; $display("FAIL first_count: got %0d expected 1", poll_count); end
    endtask

    task automatic test_debounce();
        lo1[5] = 1'b0;
        hi1[5] = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            poll();
            snap();
            checks++; if (snap_ack !== 1'b1) begin errors++; $display("FAIL deb_ack poll %0d: got %b expected 1", k, snap_ack); end
            checks++; if (buttons1 !== (k == 3 ? 12'h050 : 12'h000)) begin errors++; $display("FAIL deb_buttons1 poll %0d: got %h expected %h", k, buttons1, (k == 3 ? 12'h050 : 12'h000)); end
        end
        @(negedge clk);
        snap_req = 1'b1;
        checks++; if (snap_ack !== 1'b0) begin errors++; $display("FAIL ack_early: got %b expected 0", snap_ack); end
        @(negedge clk);
        snap_req = 1'b0;
        checks++; if (snap_ack !== 1'b1) begin errors++; $display("FAIL ack_latency: got %b expected 1", snap_ack); end
        @(negedge clk);
        checks++; if (snap_ack !== 1'b0) begin errors++; $display("FAIL ack_width: got %b expected 0", snap_ack); end
        checks++; if (buttons2 !== 12'h000) begin errors++; $display("FAIL deb_buttons2: got %h expected 000", buttons2); end
    endtask

    task automatic test_glitch();
        clear_pressed();
        lo1[0] = 1'b0;
        hi1[0] = 1'b0;
        poll();
        lo1[0] = 1'b1;
        hi1[0] = 1'b1;
        snap();
        checks++; if (buttons1 !== 12'h050) begin errors++; $display("FAIL glitch_live: got %h expected 050", buttons1); end
        repeat (3) poll();
        snap();
        checks++; if (buttons1 !== 12'h050) begin errors++; $display("FAIL glitch_after: got %h expected 050", buttons1); end
        checks++; if (pressed1 !== 12'h000) begin errors++; $display("FAIL glitch_pressed: got %h expected 000", pressed1); end
    endtask

    task automatic test_pending();
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (4) @(negedge clk);
        poll_req = 1'b1;
        @(negedge clk);
        poll_req = 1'b0;
        repeat (2) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (27) @(negedge clk);
        checks++; if (busy !== 1'b0 || poll_count !== 8'(polls_done + 1)) begin errors++; $display("FAIL pend_idle: busy %b count %0d expected 0 %0d", busy, poll_count, polls_done + 1); end
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pend_start: got %b expected 1", busy); end
        repeat (35) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pend_len: got %b expected 0", busy); end
        repeat (40) @(negedge clk);
        polls_done += 2;
        checks++; if (busy !== 1'b0 || poll_count !== 8'(polls_done)) begin errors++; $display("FAIL pend_total: busy %b count %0d expected 0 %0d", busy, poll_count, polls_done); end
    endtask

    task automatic test_snap_publish();
        lo2[8] = 1'b0;
        repeat (2) poll();
        snap();
        checks++; if (buttons2 !== 12'h000) begin errors++; $display("FAIL pub_before: got %h expected 000", buttons2); end
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (34) @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        polls_done++;
        checks++; if (snap_ack !== 1'b1) begin errors++; $display("FAIL pub_ack: got %b expected 1", snap_ack); end
        checks++; if (buttons2 !== 12'h020 || buttons1 !== 12'h050) begin errors++; $display("FAIL pub_snapshot: got %h/%h expected 050/020", buttons1, buttons2); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        snap_req = 1'b1;
        @(negedge clk);
        checks++; if (snap_ack !== 1'b1) begin errors++; $display("FAIL b2b_first: got %b expected 1", snap_ack); end
        @(negedge clk);
        snap_req = 1'b0;
        checks++; if (snap_ack !== 1'b1) begin errors++; $display("FAIL b2b_second: got %b expected 1", snap_ack); end
        @(negedge clk);
        checks++; if (snap_ack !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", snap_ack); end
    endtask

    task automatic test_edge();
        clear_pressed();
`ifdef INPUT_EDGE_DETECT_EN
        checks++; if (pressed1 !== 12'h000 || pressed2 !== 12'h000) begin errors++; $display("FAIL edge_clear: got %h/%h expected 000/000", pressed1, pressed2); end
        lo1[2] = 1'b0;
        hi1[2] = 1'b0;
        repeat (3) poll();
        checks++; if (pressed1[10] !== 1'b1 || pressed1 !== 12'h404) begin errors++; $display("FAIL edge_start: got %h expected 404", pressed1); end
        lo1 = 9'h1FF;
        hi1 = 9'h1FF;
        repeat (3) poll();
        snap();
        checks++; if (pressed1 !== 12'h404 || buttons1 !== 12'h000) begin errors++; $display("FAIL edge_sticky: pressed %h buttons %h expected 404 000", pressed1, buttons1); end
        lo1[5] = 1'b0;
        repeat (2) poll();
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (34) @(negedge clk);
        pressed_clr = 1'b1;
        @(negedge clk);
        pressed_clr = 1'b0;
        polls_done++;
        checks++; if (pressed1 !== 12'h010) begin errors++; $display("FAIL edge_clr_vs_set: got %h expected 010", pressed1); end
`else
        lo1[2] = 1'b0;
        hi1[2] = 1'b0;
        repeat (3) poll();
        snap();
        checks++; if (buttons1 !== 12'h454) begin errors++; $display("FAIL start_live: got %h expected 454", buttons1); end
        checks++; if (pressed1 !== 12'h000 || pressed2 !== 12'h000) begin errors++; $display("FAIL pressed_tied: got %h/%h expected 000/000", pressed1, pressed2); end
`endif
    endtask

    task automatic test_abort_and_divider();
        int n;
        repeat (3) @(negedge clk);
        vblank_pulse = 1'b1;
        @(negedge clk);
        vblank_pulse = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || db9_1_select !== 1'b1 || poll_count !== 8'd0) begin errors++; $display("FAIL abort_state: busy %b sel %b count %0d expected 0 1 0", busy, db9_1_select, poll_count); end
        checks++; if (buttons1 !== 12'h000 || pressed1 !== 12'h000) begin errors++; $display("FAIL abort_outputs: got %h/%h expected 000/000", buttons1, pressed1); end
        lo1 = 9'h1FF;
        hi1 = 9'h1FF;
        lo2 = 9'h1FF;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        for (int i = 1; i <= 10100; i++) begin
            @(posedge clk);
            #1;
            if (busy) begin
                n = i;
                break;
            end
        end
        checks++; if (n != 10000) begin errors++; $display("FAIL divider_period: got %0d expected 10000", n); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_pending();
        test_snap_publish();
        test_back_to_back();
        test_edge();
        test_abort_and_divider();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
